// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, control states and default width.
package alu_pkg;

  localparam int N_DEFAULT = 32;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing one register set.
// done_o marks the cycle whose edge completes the last step; result_o is that step's value.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         div_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         done_o,
  output logic [N-1:0] result_o,
  output logic         div0_o
);

  localparam int CW = $clog2(N);

  // MUL: acc = partial product, x = shifted multiplicand, y = remaining multiplier.
  // DIV: acc = remainder, x = dividend shifting out / quotient shifting in, y = divisor.
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic          div_q;
  logic          busy_q;
  logic [CW-1:0] cnt_q;

  logic [N:0]    rem_sh;
  logic [N-1:0]  diff;
  logic          ge;

  always_comb begin
    rem_sh = {acc_q, x_q[N-1]};
    ge     = rem_sh >= {1'b0, y_q};
    diff   = rem_sh[N-1:0] - y_q;
    if (div_q) begin
      acc_d = ge ? diff : rem_sh[N-1:0];
      x_d   = {x_q[N-2:0], ge};
      y_d   = y_q;
    end else begin
      acc_d = acc_q + (y_q[0] ? x_q : '0);
      x_d   = x_q << 1;
      y_d   = y_q >> 1;
    end
  end

  assign done_o   = busy_q && (cnt_q == CW'(N - 1));
  assign result_o = div_q ? x_d : acc_d;
  assign div0_o   = div_q && (y_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      acc_q  <= '0;
      x_q    <= a_i;
      y_q    <= b_i;
      div_q  <= div_i;
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: valid/ready command in, held result out; single-cycle ops computed here,
// MUL/DIV delegated to the iterative unit.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opcode,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         err
);

  localparam int SW = $clog2(N);

  state_t       state_q, state_d;
  logic [N-1:0] result_q, result_d;
  logic         err_q, err_d;

  logic [N-1:0] single_res;
  logic         single_err;
  logic         iter_start;
  logic         iter_done;
  logic [N-1:0] iter_result;
  logic         iter_div0;
  logic [SW-1:0] shamt;

  assign shamt = op_b[SW-1:0];

  always_comb begin
    single_res = '0;
    single_err = 1'b0;
    case (opcode)
      OP_ADD:  single_res = op_a + op_b;
      OP_SUB:  single_res = op_a - op_b;
      OP_AND:  single_res = op_a & op_b;
      OP_OR:   single_res = op_a | op_b;
      OP_XOR:  single_res = op_a ^ op_b;
      OP_SLL:  single_res = op_a << shamt;
      OP_SRL:  single_res = op_a >> shamt;
      default: single_err = 1'b1;
    endcase
  end

  alu_iter_unit #(.N(N)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (iter_start),
    .div_i    (opcode == OP_DIV),
    .a_i      (op_a),
    .b_i      (op_b),
    .done_o   (iter_done),
    .result_o (iter_result),
    .div0_o   (iter_div0)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    err_d      = err_q;
    iter_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_iterative(opcode)) begin
            iter_start = 1'b1;
            state_d    = ST_BUSY;
          end else begin
            result_d = single_res;
            err_d    = single_err;
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (iter_done) begin
          result_d = iter_result;
          err_d    = iter_div0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu with hand-computed expectations.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        err;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seq_alu #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  task automatic test_reset();
    #3;
    total_cnt++;
    if ({in_ready, out_valid, err} !== 3'b100 || result !== 32'd0)
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b err=%0b result=%h, want 1 0 0 0",
               in_ready, out_valid, err, result);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_single_ops();
    logic [3:0]  t_op  [9] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd2, 4'd3, 4'd0, 4'd9, 4'd15};
    logic [31:0] t_a   [9] = '{32'd2, 32'd2, 32'd2, 32'd16, 32'hC, 32'hC, 32'hFFFF_FFFF, 32'd5, 32'd7};
    logic [31:0] t_b   [9] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'hA, 32'hA, 32'd1, 32'd5, 32'd7};
    logic [31:0] t_res [9] = '{32'd5, 32'hFFFF_FFFF, 32'd16, 32'd2, 32'h8, 32'hE, 32'd0, 32'd0, 32'd0};
    logic        t_err [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      out_ready = 1'b1;
      in_valid = 1'b1; opcode = t_op[i]; op_a = t_a[i]; op_b = t_b[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== t_res[i] || err !== t_err[i])
        $display("FAIL single_op%0d: out_valid=%0b in_ready=%0b result=%h err=%0b, want 1 0 %h %0b",
                 t_op[i], out_valid, in_ready, result, err, t_res[i], t_err[i]);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL single_release%0d: out_valid=%0b in_ready=%0b, want 0 1",
                 t_op[i], out_valid, in_ready);
      else pass_cnt++;
      $display("single op=%0d a=%h b=%h -> result=%h err=%0b", t_op[i], t_a[i], t_b[i], result, err);
    end
  endtask

  task automatic test_iterative();
    logic [3:0]  t_op  [5] = '{4'd7, 4'd8, 4'd8, 4'd7, 4'd8};
    logic [31:0] t_a   [5] = '{32'd2, 32'd7, 32'd5, 32'hFFFF_FFFF, 32'd100};
    logic [31:0] t_b   [5] = '{32'd3, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] t_res [5] = '{32'd6, 32'd3, 32'hFFFF_FFFF, 32'd1, 32'd14};
    logic        t_err [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int edges;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b1;
      in_valid = 1'b1; opcode = t_op[i]; op_a = t_a[i]; op_b = t_b[i];
      edges = 0;
      do begin
        @(posedge clk); #1;
        edges++;
        // Scramble inputs after acceptance; they must not affect the running op.
        in_valid = 1'b0;
        opcode = 4'($urandom_range(0, 15));
        op_a = $urandom; op_b = $urandom;
      end while (out_valid !== 1'b1 && edges < 40);
      total_cnt++;
      if (edges !== 33)
        $display("FAIL iter_latency%0d: edges=%0d, want 33", t_op[i], edges);
      else pass_cnt++;
      total_cnt++;
      if (result !== t_res[i] || err !== t_err[i])
        $display("FAIL iter_result%0d: result=%h err=%0b, want %h %0b",
                 t_op[i], result, err, t_res[i], t_err[i]);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL iter_release%0d: out_valid=%0b in_ready=%0b, want 0 1",
                 t_op[i], out_valid, in_ready);
      else pass_cnt++;
      $display("iter op=%0d a=%h b=%h -> result=%h err=%0b edges=%0d",
               t_op[i], t_a[i], t_b[i], result, err, edges);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; opcode = 4'd4; op_a = 32'd6; op_b = 32'd3;
    @(posedge clk); #1;
    // Keep offering a different command; it must be ignored while the result is held.
    opcode = 4'd0; op_a = 32'd100; op_b = 32'd200;
    for (int c = 0; c < 5; c++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd5 || err !== 1'b0)
        $display("FAIL hold_cycle%0d: out_valid=%0b in_ready=%0b result=%h err=%0b, want 1 0 5 0",
                 c, out_valid, in_ready, result, err);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total_cnt++;
    if (out_valid !== 1'b1 || result !== 32'd5)
      $display("FAIL hold_final: out_valid=%0b result=%h, want 1 5", out_valid, result);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL hold_transfer: out_valid=%0b in_ready=%0b, want 0 1", out_valid, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL hold_single: out_valid=%0b, want 0", out_valid);
    else pass_cnt++;
    $display("backpressure xor 6^3 held 5 cycles -> result=%h", result);
  endtask

  task automatic test_reset_mid_mul();
    int stray;
    out_ready = 1'b1;
    in_valid = 1'b1; opcode = 4'd7; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || err !== 1'b0)
      $display("FAIL reset_async: in_ready=%0b out_valid=%0b result=%h err=%0b, want 1 0 0 0",
               in_ready, out_valid, result, err);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) stray++;
    end
    total_cnt++;
    if (stray !== 0)
      $display("FAIL reset_discard: out_valid cycles=%0d, want 0", stray);
    else pass_cnt++;
    $display("reset mid-MUL -> stray out_valid cycles=%0d", stray);
  endtask

  task automatic test_after_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; opcode = 4'd0; op_a = 32'd10; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || result !== 32'd30 || err !== 1'b0)
      $display("FAIL post_reset_add: out_valid=%0b result=%h err=%0b, want 1 1e 0",
               out_valid, result, err);
    else pass_cnt++;
    @(posedge clk); #1;
    $display("post-reset add 10+20 -> result=%h", result);
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_iterative();
    test_backpressure();
    test_reset_mid_mul();
    test_after_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter N, default 32, operand and result width in bits.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port in_valid  input  1  command present on opcode/op_a/op_b.
REQ-005 Port in_ready  output  1  block can accept a command this cycle.
REQ-006 Port opcode  input  4  operation select.
REQ-007 Port op_a  input  N  first operand, unsigned.
REQ-008 Port op_b  input  N  second operand, unsigned.
REQ-009 Port out_valid  output  1  result/flags valid.
REQ-010 Port out_ready  input  1  consumer accepts result this cycle.
REQ-011 Port result  output  N  operation result.
REQ-012 Port err  output  1  illegal opcode or divide-by-zero for the held result.

Function
REQ-013 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL (by op_b[log2 N-1:0]), 6 SRL (same), 7 MUL, 8 DIV; 9-15 illegal.
REQ-014 ADD/SUB SHALL wrap modulo 2^N; MUL SHALL return low N bits of the product; DIV SHALL return unsigned quotient.
REQ-015 A command SHALL be accepted on a rising edge where in_valid and in_ready are both 1; operands and opcode SHALL be captured at that edge.
REQ-016 in_ready SHALL be 1 only in state IDLE.
REQ-017 States: IDLE, BUSY, DONE; IDLE->DONE on accept of opcode 0-6 or 9-15; IDLE->BUSY on accept of opcode 7/8; BUSY->DONE when iteration count reaches N; DONE->IDLE on out_ready.
REQ-018 Opcodes 0-6 and illegal: out_valid SHALL assert on the edge following acceptance (latency 1).
REQ-019 MUL SHALL be iterative shift-add, DIV iterative restoring, one bit per cycle; out_valid SHALL assert exactly N+1 edges after acceptance.
REQ-020 out_valid SHALL be 1 only in DONE; result and err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 No new command SHALL be accepted in the cycle out_ready completes a transfer (in_ready=0 in DONE); earliest next accept is the following edge.
REQ-022 Illegal opcode: result=0, err=1.
REQ-023 DIV with op_b=0: result all ones, err=1, full N+1 latency retained.
REQ-024 Input changes while BUSY or DONE SHALL have no effect.
REQ-025 err SHALL be 0 for every legal non-faulting operation.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, in_ready=1, out_valid=0, result=0, err=0, iteration count 0, regardless of clock.
REQ-027 Reset asserted mid-BUSY or mid-DONE SHALL discard the operation; no out_valid SHALL follow release.
REQ-028 First accept after release SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode constants, state encoding, and default N.
REQ-030 Iterative MUL/DIV datapath SHALL be a sub-module alu_iter_unit (start, op select, operands in; done, result, div0 out); control FSM and single-cycle ops stay in seq_alu.

Verification
REQ-031 Accept opcode 0, a=2, b=3, out_ready=1 -> next edge out_valid=1, result=5, err=0.
REQ-032 Opcode 1, a=2, b=3 -> result=0xFFFFFFFF; opcode 5, a=2, b=3 -> result=16; opcode 6, a=16, b=3 -> result=2.
REQ-033 Opcode 7, a=2, b=3 -> out_valid exactly 33 edges after accept, result=6; opcode 8, a=7, b=2 -> result=3 after 33 edges.
REQ-034 Opcode 8, b=0 -> result=0xFFFFFFFF, err=1; opcode 9 -> result=0, err=1 after 1 edge.
REQ-035 Hold out_ready=0 for 5 cycles after opcode 4, a=6, b=3 -> result=5 stable, in_ready=0 throughout, single transfer when out_ready=1.
REQ-036 Pulse rst_n low 10 cycles into a MUL -> in_ready=1, out_valid=0 immediately, no result after release.
